// File: rtl/pll_status_pkg.sv
// Shared types and helpers for the multi-PLL status and reset sequencer.
package pll_status_pkg;

    typedef enum logic [1:0] {
        PD        = 2'd0,
        WAIT_LOCK = 2'd1,
        MCGB      = 2'd2,
        LOCKED    = 2'd3
    } pll_state_e;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_status_chan.sv
// One PLL channel: lock synchroniser, powerdown/lock/MCGB sequencing FSM,
// saturating counters and sticky lock-loss / timeout flags.
module pll_status_chan
    import pll_status_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int PD_HOLD_CYC      = 16,
    parameter int LOCK_FILT_CYC    = 64,
    parameter int MCGB_RST_CYC     = 8,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int AUTO_RELOCK      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked_in,
    input  logic pll_powerdown_req,
    input  logic clear_sticky,
    output logic pll_powerdown,
    output logic mcgb_rst,
    output logic pll_locked_out,
    output logic lock_lost_sticky,
    output logic timeout_err
);

    localparam int MAX_TERM = max_int(max_int(PD_HOLD_CYC, LOCK_FILT_CYC),
                                      max_int(MCGB_RST_CYC, LOCK_TIMEOUT_CYC));
    localparam int CNT_W    = cnt_width(MAX_TERM);

    localparam logic [CNT_W-1:0] PD_LIM   = CNT_W'(PD_HOLD_CYC);
    localparam logic [CNT_W-1:0] FILT_LIM = CNT_W'(LOCK_FILT_CYC);
    localparam logic [CNT_W-1:0] MCGB_LIM = CNT_W'(MCGB_RST_CYC);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(LOCK_TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lk_s;

    pll_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       filt_q, filt_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;

    logic                   powerdown_q, powerdown_d;
    logic                   mcgb_rst_q, mcgb_rst_d;
    logic                   locked_q, locked_d;
    logic                   lock_lost_sticky_q, lock_lost_sticky_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   lost_evt;
    logic                   tmo_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] lim);
        return (val >= lim) ? val : val + CNT_W'(1);
    endfunction

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked_in};
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Terminal counts compare against the incremented value so each phase
    // lasts exactly its configured number of cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        tmo_d    = tmo_q;
        lost_evt = 1'b0;
        tmo_evt  = 1'b0;

        unique case (state_q)
            PD: begin
                cnt_d = sat_inc(cnt_q, PD_LIM);
                if ((cnt_d == PD_LIM) && !pll_powerdown_req) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                filt_d = lk_s ? sat_inc(filt_q, FILT_LIM) : '0;
                tmo_d  = sat_inc(tmo_q, TMO_LIM);
                if (lk_s && (filt_d == FILT_LIM)) begin
                    state_d = MCGB;
                end else if (tmo_d == TMO_LIM) begin
                    tmo_evt = 1'b1;
                    state_d = PD;
                end
            end
            MCGB: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    cnt_d = sat_inc(cnt_q, MCGB_LIM);
                    if (cnt_d == MCGB_LIM) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!lk_s) begin
                    lost_evt = 1'b1;
                    if (AUTO_RELOCK != 0) begin
                        state_d = PD;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
            end
            default: begin
                state_d = PD;
            end
        endcase

        // The request overrides the move but a lock loss still records itself.
        if (pll_powerdown_req) begin
            state_d = PD;
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            filt_d = '0;
            tmo_d  = '0;
        end
    end

    always_comb begin
        powerdown_d        = (state_d == PD);
        mcgb_rst_d         = (state_d != LOCKED);
        locked_d           = (state_d == LOCKED);
        lock_lost_sticky_d = lost_evt | (lock_lost_sticky_q & ~clear_sticky);
        timeout_err_d      = tmo_evt | (timeout_err_q & ~clear_sticky);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q             <= '0;
            state_q            <= PD;
            cnt_q              <= '0;
            filt_q             <= '0;
            tmo_q              <= '0;
            powerdown_q        <= 1'b1;
            mcgb_rst_q         <= 1'b1;
            locked_q           <= 1'b0;
            lock_lost_sticky_q <= 1'b0;
            timeout_err_q      <= 1'b0;
        end else begin
            sync_q             <= sync_d;
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            filt_q             <= filt_d;
            tmo_q              <= tmo_d;
            powerdown_q        <= powerdown_d;
            mcgb_rst_q         <= mcgb_rst_d;
            locked_q           <= locked_d;
            lock_lost_sticky_q <= lock_lost_sticky_d;
            timeout_err_q      <= timeout_err_d;
        end
    end

    assign pll_powerdown    = powerdown_q;
    assign mcgb_rst         = mcgb_rst_q;
    assign pll_locked_out   = locked_q;
    assign lock_lost_sticky = lock_lost_sticky_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: rtl/pll_status_sequencer.sv
// Multi-PLL status and reset sequencer: N_PLL independent channels plus a
// registered all-locked flag for the transceiver reset controller.
module pll_status_sequencer
    import pll_status_pkg::*;
#(
    parameter int N_PLL            = 1,
    parameter int SYNC_STAGES      = 2,
    parameter int PD_HOLD_CYC      = 16,
    parameter int LOCK_FILT_CYC    = 64,
    parameter int MCGB_RST_CYC     = 8,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int AUTO_RELOCK      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_PLL-1:0] pll_locked_in,
    input  logic [N_PLL-1:0] pll_powerdown_req,
    input  logic             clear_sticky,
    output logic [N_PLL-1:0] pll_powerdown,
    output logic [N_PLL-1:0] mcgb_rst,
    output logic [N_PLL-1:0] pll_locked_out,
    output logic             all_locked,
    output logic [N_PLL-1:0] lock_lost_sticky,
    output logic [N_PLL-1:0] timeout_err
);

    logic [N_PLL-1:0] locked_vec;
    logic             all_locked_q, all_locked_d;

    for (genvar i = 0; i < N_PLL; i++) begin : g_chan
        pll_status_chan #(
            .SYNC_STAGES      (SYNC_STAGES),
            .PD_HOLD_CYC      (PD_HOLD_CYC),
            .LOCK_FILT_CYC    (LOCK_FILT_CYC),
            .MCGB_RST_CYC     (MCGB_RST_CYC),
            .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
            .AUTO_RELOCK      (AUTO_RELOCK)
        ) u_chan (
            .clk               (clk),
            .reset_n           (reset_n),
            .pll_locked_in     (pll_locked_in[i]),
            .pll_powerdown_req (pll_powerdown_req[i]),
            .clear_sticky      (clear_sticky),
            .pll_powerdown     (pll_powerdown[i]),
            .mcgb_rst          (mcgb_rst[i]),
            .pll_locked_out    (locked_vec[i]),
            .lock_lost_sticky  (lock_lost_sticky[i]),
            .timeout_err       (timeout_err[i])
        );
    end

    // Built from the registered per-channel flags, so it trails them by a cycle.
    always_comb begin
        all_locked_d = &locked_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= all_locked_d;
        end
    end

    assign pll_locked_out = locked_vec;
    assign all_locked     = all_locked_q;

endmodule

// File: tb/tb_pll_status_sequencer.sv
// Bench for pll_status_sequencer: two instances (auto-relock on/off) driven
// with the same stimulus and compared every cycle against a timestamp model.
module tb_pll_status_sequencer;

    localparam int N_PLL    = 2;
    localparam int SYNC     = 2;
    localparam int PD_HOLD  = 4;
    localparam int FILT     = 4;
    localparam int MCGB_CYC = 3;
    localparam int TIMEOUT  = 20;

    // Model phases: powered off, hunting for lock, settling the CGB, up.
    localparam int OFF    = 0;
    localparam int HUNT   = 1;
    localparam int SETTLE = 2;
    localparam int UP     = 3;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] lock_in = 2'b00;
    logic [1:0] req     = 2'b00;
    logic       clear   = 1'b0;

    logic [1:0] pd_a, mr_a, lo_a, lost_a, to_a;
    logic       all_a;
    logic [1:0] pd_b, mr_b, lo_b, lost_b, to_b;
    logic       all_b;

    always #5 clk = ~clk;

    pll_status_sequencer #(
        .N_PLL(N_PLL), .SYNC_STAGES(SYNC), .PD_HOLD_CYC(PD_HOLD),
        .LOCK_FILT_CYC(FILT), .MCGB_RST_CYC(MCGB_CYC),
        .LOCK_TIMEOUT_CYC(TIMEOUT), .AUTO_RELOCK(1)
    ) dut_relock (
        .clk(clk), .reset_n(reset_n), .pll_locked_in(lock_in),
        .pll_powerdown_req(req), .clear_sticky(clear),
        .pll_powerdown(pd_a), .mcgb_rst(mr_a), .pll_locked_out(lo_a),
        .all_locked(all_a), .lock_lost_sticky(lost_a), .timeout_err(to_a)
    );

    pll_status_sequencer #(
        .N_PLL(N_PLL), .SYNC_STAGES(SYNC), .PD_HOLD_CYC(PD_HOLD),
        .LOCK_FILT_CYC(FILT), .MCGB_RST_CYC(MCGB_CYC),
        .LOCK_TIMEOUT_CYC(TIMEOUT), .AUTO_RELOCK(0)
    ) dut_hold (
        .clk(clk), .reset_n(reset_n), .pll_locked_in(lock_in),
        .pll_powerdown_req(req), .clear_sticky(clear),
        .pll_powerdown(pd_b), .mcgb_rst(mr_b), .pll_locked_out(lo_b),
        .all_locked(all_b), .lock_lost_sticky(lost_b), .timeout_err(to_b)
    );

    int checks = 0;
    int errors = 0;
    int now    = 0;

    logic [SYNC-1:0] syn_m [2];
    int              phase     [2][2];
    int              t_enter   [2][2];
    int              run_start [2][2];
    logic [1:0]      exp_pd [2];
    logic [1:0]      exp_mr [2];
    logic [1:0]      exp_lo [2];
    logic [1:0]      exp_lost [2];
    logic [1:0]      exp_to [2];
    logic            exp_all [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) syn_m[c] = '0;
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 2; c++) begin
                phase[v][c]     = OFF;
                t_enter[v][c]   = now;
                run_start[v][c] = now;
            end
            exp_pd[v]   = 2'b11;
            exp_mr[v]   = 2'b11;
            exp_lo[v]   = 2'b00;
            exp_lost[v] = 2'b00;
            exp_to[v]   = 2'b00;
            exp_all[v]  = 1'b0;
        end
    endtask

    // Advances the model by one clock edge using the inputs present now.
    task automatic model_edge();
        logic [1:0] lk;
        int         n;
        int         nxt;
        logic       lost;
        logic       tout;
        logic       all_next;
        for (int c = 0; c < 2; c++) begin
            lk[c]    = syn_m[c][SYNC-1];
            syn_m[c] = {syn_m[c][SYNC-2:0], lock_in[c]};
        end
        n = now + 1;
        for (int v = 0; v < 2; v++) begin
            all_next = &exp_lo[v];
            for (int c = 0; c < 2; c++) begin
                lost = 1'b0;
                tout = 1'b0;
                nxt  = phase[v][c];
                if (phase[v][c] == HUNT && !lk[c]) run_start[v][c] = n;
                case (phase[v][c])
                    OFF: begin
                        if ((n - t_enter[v][c] >= PD_HOLD) && !req[c]) nxt = HUNT;
                    end
                    HUNT: begin
                        if (lk[c] && (n - run_start[v][c] >= FILT)) nxt = SETTLE;
                        else if (n - t_enter[v][c] >= TIMEOUT) begin
                            tout = 1'b1;
                            nxt  = OFF;
                        end
                    end
                    SETTLE: begin
                        if (!lk[c]) nxt = HUNT;
                        else if (n - t_enter[v][c] >= MCGB_CYC) nxt = UP;
                    end
                    default: begin
                        if (!lk[c]) begin
                            lost = 1'b1;
                            nxt  = (v == 0) ? OFF : HUNT;
                        end
                    end
                endcase
                if (req[c]) nxt = OFF;
                if (nxt != phase[v][c]) begin
                    phase[v][c]     = nxt;
                    t_enter[v][c]   = n;
                    run_start[v][c] = n;
                end
                if (lost) exp_lost[v][c] = 1'b1;
                else if (clear) exp_lost[v][c] = 1'b0;
                if (tout) exp_to[v][c] = 1'b1;
                else if (clear) exp_to[v][c] = 1'b0;
                exp_pd[v][c] = (phase[v][c] == OFF);
                exp_mr[v][c] = (phase[v][c] != UP);
                exp_lo[v][c] = (phase[v][c] == UP);
            end
            exp_all[v] = all_next;
        end
        now = n;
    endtask

    task automatic check_bits(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput();
        check_bits("relock.powerdown", pd_a, exp_pd[0]);
        check_bits("relock.mcgb_rst", mr_a, exp_mr[0]);
        check_bits("relock.locked_out", lo_a, exp_lo[0]);
        check_bits("relock.all_locked", {1'b0, all_a}, {1'b0, exp_all[0]});
        check_bits("relock.lock_lost", lost_a, exp_lost[0]);
        check_bits("relock.timeout", to_a, exp_to[0]);
        check_bits("hold.powerdown", pd_b, exp_pd[1]);
        check_bits("hold.mcgb_rst", mr_b, exp_mr[1]);
        check_bits("hold.locked_out", lo_b, exp_lo[1]);
        check_bits("hold.all_locked", {1'b0, all_b}, {1'b0, exp_all[1]});
        check_bits("hold.lock_lost", lost_b, exp_lost[1]);
        check_bits("hold.timeout", to_b, exp_to[1]);
    endtask

    task automatic applyStimulus(input logic [1:0] lk, input logic [1:0] rq, input logic clr);
        lock_in = lk;
        req     = rq;
        clear   = clr;
        model_edge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic check_reset_values(input string tag);
        check_bits({tag, ".pd"}, pd_a, 2'b11);
        check_bits({tag, ".mr"}, mr_a, 2'b11);
        check_bits({tag, ".lo"}, lo_a, 2'b00);
        check_bits({tag, ".all"}, {1'b0, all_a}, 2'b00);
        check_bits({tag, ".lost"}, lost_a, 2'b00);
        check_bits({tag, ".to"}, to_a, 2'b00);
        check_bits({tag, ".pd_b"}, pd_b, 2'b11);
        check_bits({tag, ".mr_b"}, mr_b, 2'b11);
        check_bits({tag, ".lo_b"}, lo_b, 2'b00);
        check_bits({tag, ".lost_b"}, lost_b, 2'b00);
    endtask

    initial begin
        logic [1:0] lk_r;
        logic [1:0] rq_r;
        logic       found;

        // Asynchronous reset with no clock edge involved.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Powerdown held for PD_HOLD cycles after reset release.
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 1'b0);
        check_bits("pd_hold.early", pd_a, 2'b11);
        applyStimulus(2'b00, 2'b00, 1'b0);
        check_bits("pd_hold.release", pd_a, 2'b00);
        check_bits("pd_hold.release_b", pd_b, 2'b00);

        // Lock on channel 0: SYNC + FILT + MCGB = 9 cycles to locked_out.
        for (int i = 0; i < 8; i++) applyStimulus(2'b01, 2'b00, 1'b0);
        check_bits("lock0.before", lo_a, 2'b00);
        applyStimulus(2'b01, 2'b00, 1'b0);
        check_bits("lock0.latency", lo_a, 2'b01);
        check_bits("lock0.latency_b", lo_b, 2'b01);
        check_bits("lock0.all_low", {1'b0, all_a}, 2'b00);

        // Channel 1 never locks: timeout after 20 WAIT_LOCK cycles.
        for (int i = 0; i < 10; i++) applyStimulus(2'b01, 2'b00, 1'b0);
        check_bits("timeout1.before", to_a, 2'b00);
        applyStimulus(2'b01, 2'b00, 1'b0);
        check_bits("timeout1.flag", to_a, 2'b10);
        check_bits("timeout1.flag_b", to_b, 2'b10);
        check_bits("timeout1.pd", pd_a, 2'b10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 2'b00, 1'b0);
            check_bits("timeout1.pd_hold", pd_a, 2'b10);
        end
        applyStimulus(2'b01, 2'b00, 1'b0);
        check_bits("timeout1.retry", pd_a, 2'b00);

        // Lock glitch on channel 1: 3 high, 1 low, then stable high.
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(2'b11, 2'b00, 1'b0);
        check_bits("glitch1.before", lo_a, 2'b01);
        applyStimulus(2'b11, 2'b00, 1'b0);
        check_bits("glitch1.latency", lo_a, 2'b11);
        check_bits("glitch1.all_low", {1'b0, all_a}, 2'b00);
        applyStimulus(2'b11, 2'b00, 1'b0);
        check_bits("glitch1.all_high", {1'b0, all_a}, 2'b01);
        check_bits("glitch1.all_high_b", {1'b0, all_b}, 2'b01);

        // Lock loss on channel 0 in LOCKED.
        applyStimulus(2'b10, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b0);
        check_bits("loss0.still", lo_a, 2'b11);
        applyStimulus(2'b10, 2'b00, 1'b0);
        check_bits("loss0.lo", lo_a, 2'b10);
        check_bits("loss0.sticky", lost_a, 2'b01);
        check_bits("loss0.pd", pd_a, 2'b01);
        check_bits("loss0.mr", mr_a, 2'b01);
        check_bits("loss0.all_lag", {1'b0, all_a}, 2'b01);
        check_bits("loss0.lo_b", lo_b, 2'b10);
        check_bits("loss0.sticky_b", lost_b, 2'b01);
        check_bits("loss0.pd_b", pd_b, 2'b00);
        check_bits("loss0.mr_b", mr_b, 2'b01);
        applyStimulus(2'b10, 2'b00, 1'b0);
        check_bits("loss0.all_drop", {1'b0, all_a}, 2'b00);
        check_bits("loss0.all_drop_b", {1'b0, all_b}, 2'b00);

        // Clear coinciding with a new loss on channel 1: set wins.
        applyStimulus(2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b1);
        check_bits("clear_vs_set", lost_a, 2'b10);
        check_bits("clear_vs_set_b", lost_b, 2'b10);
        check_bits("clear_timeout", to_a, 2'b00);
        applyStimulus(2'b00, 2'b00, 1'b0);

        // Reach MCGB on channel 0, then reset asynchronously.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            applyStimulus(2'b11, 2'b00, 1'b0);
            if (phase[0][0] == SETTLE) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL mcgb_wait: observed no MCGB entry, expected within 60 cycles");
        end
        check_bits("mcgb.pd", {1'b0, pd_a[0]}, 2'b00);
        check_bits("mcgb.mr", {1'b0, mr_a[0]}, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("mid_mcgb_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic against the model.
        lk_r = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (lk_r[c] ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 7) == 0))
                    lk_r[c] = ~lk_r[c];
                rq_r[c] = ($urandom_range(0, 39) == 0);
            end
            applyStimulus(lk_r, rq_r, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_status_sequencer.md
Name: pll_status_sequencer

Overview:
- Parametrised multi-PLL status and reset sequencer. Successor to the single-PLL pass-through status interconnect.
- Sits between the transceiver reset controller and N_PLL transmit PLLs with their master CGBs.
- Per PLL it performs:
  - synchronisation and debounce of pll_locked;
  - enforcement of a minimum powerdown pulse;
  - sequencing of mcgb_rst release after lock;
  - lock-timeout and lock-loss detection with sticky status.
- Also produces an aggregate all-locked flag for the reset controller.

Parameters:
- N_PLL, 1, number of PLL channels.
- SYNC_STAGES, 2, synchroniser depth on pll_locked_in (min 2).
- PD_HOLD_CYC, 16, minimum cycles pll_powerdown is held high once asserted (min 1).
- LOCK_FILT_CYC, 64, consecutive cycles synced lock must be high before lock is accepted (min 1).
- MCGB_RST_CYC, 8, cycles mcgb_rst stays high after lock is accepted (min 1).
- LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before a timeout.
- AUTO_RELOCK, 1: 1 = on lock loss, power down and restart; 0 = return to WAIT_LOCK only.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked_in  in  N_PLL  raw PLL lock indicators, asynchronous to clk.
- pll_powerdown_req  in  N_PLL  powerdown request from reset controller, synchronous to clk.
- clear_sticky  in  1  single-cycle pulse; clears lock_lost_sticky and timeout_err.
- pll_powerdown  out  N_PLL  PLL powerdown to hard IP.
- mcgb_rst  out  N_PLL  master CGB reset.
- pll_locked_out  out  N_PLL  qualified lock status.
- all_locked  out  1  AND of pll_locked_out, registered.
- lock_lost_sticky  out  N_PLL  set when a lock is lost in LOCKED.
- timeout_err  out  N_PLL  set when a WAIT_LOCK timeout occurs.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - every channel is in PD;
  - pll_powerdown = all 1s; mcgb_rst = all 1s;
  - pll_locked_out = 0; all_locked = 0; sticky flags = 0;
  - all counters = 0; synchroniser flops = 0.
- Synchroniser: pll_locked_in passes through a SYNC_STAGES flop chain, giving lk_s. All FSM decisions use lk_s.
- Registered outputs: all outputs are decoded from the next state and registered, so they change in the same cycle the state register does.
- Per-channel FSM, 4 states:
  - PD:
    - powerdown = 1, mcgb_rst = 1, locked_out = 0.
    - cnt increments to PD_HOLD_CYC, then saturates.
    - Go to WAIT_LOCK when cnt == PD_HOLD_CYC and req = 0.
    - Entering PD clears cnt.
  - WAIT_LOCK:
    - powerdown = 0, mcgb_rst = 1.
    - Filter counter increments while lk_s = 1 and clears to 0 when lk_s = 0.
    - Go to MCGB when the filter reaches LOCK_FILT_CYC.
    - Timeout counter increments every cycle in this state. When it reaches LOCK_TIMEOUT_CYC: set timeout_err and go to PD.
  - MCGB:
    - powerdown = 0, mcgb_rst = 1.
    - Count MCGB_RST_CYC cycles, then go to LOCKED.
    - If lk_s = 0, go to WAIT_LOCK instead; this is not counted as a lock loss.
  - LOCKED:
    - powerdown = 0, mcgb_rst = 0, locked_out = 1.
    - If lk_s = 0: set lock_lost_sticky; go to PD if AUTO_RELOCK = 1, else to WAIT_LOCK (mcgb_rst reasserts).
- Priority: pll_powerdown_req = 1 in any state forces PD on the next edge. This overrides lock loss, but a lock loss in LOCKED in that same cycle still sets its sticky bit.
- Latency: after lk_s rises in WAIT_LOCK with the filter at 0, pll_locked_out rises exactly LOCK_FILT_CYC + MCGB_RST_CYC cycles later. From a stable pll_locked_in edge the total adds SYNC_STAGES.
- all_locked: registered AND of pll_locked_out, one cycle behind. It drops one cycle after any channel leaves LOCKED.
- Sticky flags:
  - clear_sticky clears both sticky vectors.
  - A set and a clear in the same cycle: set wins.
- Counter widths: $clog2(max + 1) of the largest terminal count. Counters saturate and never wrap.
- Independence: channels share nothing except clear_sticky and the all_locked AND.

Decomposition:
- Package pll_status_pkg:
  - state enum {PD, WAIT_LOCK, MCGB, LOCKED};
  - function returning the counter width.
- Sub-module pll_status_chan: one channel, containing the synchroniser, FSM, counters and sticky bits.
- Top level: generate-instantiates N_PLL channels and the all_locked register.

Test Plan:
- Bench parameters for all scenarios: N_PLL=2, SYNC=2, PD_HOLD=4, FILT=4, MCGB=3, TIMEOUT=20.
- Reset release with req=0, then raise lock0 -> powerdown0 falls 4 cycles after reset; locked_out0 rises 9 cycles after the lock0 edge; all_locked stays 0 until lock1 also completes.
- Lock glitch: lock0 high 3 cycles, low 1, then high -> filter restarts; locked_out0 rises 9 cycles after the final rising edge.
- Lock never asserted on ch1 -> timeout_err[1] = 1 after 20 WAIT_LOCK cycles; powerdown1 = 1 for ≥4 cycles; WAIT_LOCK retries.
- Lock loss in LOCKED, AUTO_RELOCK=1 -> lock_lost_sticky set; powerdown and mcgb_rst rise; all_locked drops 1 cycle after locked_out.
- Lock loss in LOCKED with AUTO_RELOCK=0 -> channel goes to WAIT_LOCK; powerdown stays 0; mcgb_rst reasserts.
- Edge cases:
  - clear_sticky in the same cycle as a new loss -> bit stays 1.
  - reset_n low mid-MCGB -> all outputs return to reset values immediately (asynchronously).
